// File: rtl/mult_div_pkg.sv
// Shared op codes, FSM state encoding and default latencies for the Hi/Lo multiply/divide unit.
// Optional accumulate ops (madd/maddu/msub/msubu) are decoded only when MULT_DIV_MADD_EN is defined.
package mult_div_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mult_op(input logic [3:0] op);
    logic hit;
    hit = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MULT_DIV_MADD_EN
    hit = hit || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return hit;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Execute-stage <-> multiply/divide unit signals. The stage drives op/operands with Start;
// the unit returns Busy, the architectural Hi/Lo and its FSM state for observation.
interface mult_div_if;
  // Start qualifies MDCtr/A1/A2 for exactly the cycle it is high; there is no ready:
  // the unit silently drops Start while Busy, and upstream must stall on Busy itself.
  logic [31:0]          A1;
  logic [31:0]          A2;
  logic [3:0]           MDCtr;
  logic                 Start;
  logic                 Busy;
  logic [31:0]          Hi;
  logic [31:0]          Lo;
  mult_div_pkg::state_t dbg_state;

  modport master (output A1, A2, MDCtr, Start, input Busy, Hi, Lo, dbg_state);
  modport slave  (input A1, A2, MDCtr, Start, output Busy, Hi, Lo, dbg_state);
endinterface

// File: rtl/md_calc.sv
// Combinational result datapath: 64-bit product/quotient-remainder/accumulate and a write enable.
// Accumulate paths exist only when MULT_DIV_MADD_EN is defined.
module md_calc
  import mult_div_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        we
);

  logic [63:0] prod_s, prod_u;
  logic        sgn, dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quo, rem;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a1[31]}}, a1} * {{32{a2[31]}}, a2};
  assign prod_u = {32'b0, a1} * {32'b0, a2};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign sgn      = (op == MD_DIV);
  assign dvd_neg  = sgn & a1[31];
  assign dvs_neg  = sgn & a2[31];
  assign dvd_mag  = dvd_neg ? -a1 : a1;
  assign dvs_mag  = dvs_neg ? -a2 : a2;
  assign dvs_safe = (a2 == 32'd0) ? 32'd1 : dvs_mag;
  assign q_mag    = dvd_mag / dvs_safe;
  assign r_mag    = dvd_mag % dvs_safe;
  assign quo      = (dvd_neg ^ dvs_neg) ? -q_mag : q_mag;
  assign rem      = dvd_neg ? -r_mag : r_mag;

`ifndef MULT_DIV_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    res = 64'd0;
    we  = 1'b0;
    case (op)
      MD_MULT:           begin res = prod_s; we = 1'b1; end
      MD_MULTU:          begin res = prod_u; we = 1'b1; end
      MD_DIV, MD_DIVU:   begin res = {rem, quo}; we = (a2 != 32'd0); end
`ifdef MULT_DIV_MADD_EN
      MD_MADD:           begin res = {hi, lo} + prod_s; we = 1'b1; end
      MD_MADDU:          begin res = {hi, lo} + prod_u; we = 1'b1; end
      MD_MSUB:           begin res = {hi, lo} - prod_s; we = 1'b1; end
      MD_MSUBU:          begin res = {hi, lo} - prod_u; we = 1'b1; end
`endif
      default:           begin res = 64'd0; we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit owning Hi/Lo: fixed-latency mult/div with Busy, plus mthi/mtlo.
// madd/maddu/msub/msubu are available when MULT_DIV_MADD_EN is defined.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [63:0]   res_q, res_n, calc_res;
  logic          we_q, we_n, calc_we;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;
  logic          op_mult, op_div;

  // Operands are consumed at Start, so the result is latched then and A1/A2 may move on.
  md_calc u_calc (
    .op  (bus.MDCtr),
    .a1  (bus.A1),
    .a2  (bus.A2),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res),
    .we  (calc_we)
  );

  assign op_mult = is_mult_op(bus.MDCtr);
  assign op_div  = is_div_op(bus.MDCtr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      res_q <= 64'd0;
      we_q  <= 1'b0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      res_q <= res_n;
      we_q  <= we_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_n   = res_q;
    we_n    = we_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          if (op_mult || op_div) begin
            res_n   = calc_res;
            we_n    = calc_we;
            cnt_n   = op_div ? DIV_LOAD : MULT_LOAD;
            state_n = ST_RUN;
          end else if (bus.MDCtr == MD_MTHI) begin
            hi_n = bus.A1;
          end else if (bus.MDCtr == MD_MTLO) begin
            lo_n = bus.A1;
          end
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          if (we_q) begin
            hi_n = res_q[63:32];
            lo_n = res_q[31:0];
          end
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.Busy      = (state == ST_RUN);
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the MIPS execute stage. It owns the architectural Hi and Lo registers, executes mult/multu/div/divu and mthi/mtlo, and drives Hi/Lo straight into the ALU's Hi/Lo inputs for mfhi/mflo. It asserts Busy while an operation is in flight, so the hazard unit stalls any subsequent Hi/Lo access.

## Interface
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu (and madd-class ops); must be ≥1.
- DIV_CYCLES, 10, Busy duration in cycles for div/divu; must be ≥1.
- Clock: one clock. Reset: asynchronous, active-high.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- A2  in  32  rt operand (divisor / multiplier).
- MDCtr  in  4  op: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, 1001 msub, 1010 msubu; other codes none.
- Start  in  1  qualifies MDCtr/A1/A2 this cycle.
- Busy  out  1  operation in flight.
- Hi  out  32  Hi register.
- Lo  out  32  Lo register.

## Operation
- States: IDLE, RUN. Counter cnt, operation-result register res[63:0].
- In IDLE, Start with a mult/div-class op: A1, A2 and MDCtr are sampled; the 64-bit result is computed into res; cnt loads N−1 (N = MULT_CYCLES or DIV_CYCLES); state → RUN.
- In RUN, cnt decrements each cycle. On the edge where cnt==0: {Hi,Lo} ← res (div by zero: Hi/Lo unchanged), state → IDLE.
- mthi/mtlo with Start in IDLE: Hi (resp. Lo) ← A1 at that edge; no Busy; the other register is untouched.
- Start while in RUN (any op, including mthi/mtlo): ignored, no state change. Upstream stalls instead.
- mult: signed 32×32→64, {Hi,Lo} = product. multu: unsigned.
- div: signed, truncating toward zero; Lo = quotient, Hi = remainder, remainder carries the dividend's sign. 0x80000000 / −1 gives Lo=0x80000000, Hi=0. divu: unsigned.
- madd/maddu: {Hi,Lo} ← {Hi,Lo} + product. msub/msubu: {Hi,Lo} ← {Hi,Lo} − product. The product and accumulate use Hi/Lo as sampled at Start; arithmetic is modulo 2^64.
- Reset (any time, including mid-RUN): state IDLE, Busy=0, Hi=0, Lo=0, cnt=0. The in-flight result is discarded.

## Timing
- Start sampled at edge t. Busy=1 in cycles t+1 … t+N. Hi/Lo new values are visible from cycle t+N+1, which is also the cycle in which Busy=0.
- Busy is a registered output and rises the cycle after Start, so the hazard unit must also treat "Start with a mult/div-class op this cycle" as busy.
- mthi/mtlo: the new value is visible at cycle t+1.
- A new op may Start in the same cycle Busy falls.
- A1/A2 may change freely after the Start cycle.

## Configuration
- MULT_DIV_MADD_EN defined: codes 0111–1010 perform madd/maddu/msub/msubu with MULT_CYCLES latency.
- Not defined: codes 0111–1010 decode as none. No state change, Busy stays 0, and no accumulate logic is built.

## Structure
- Package mult_div_pkg holds the MDCtr op-code localparams (MD_NONE, MD_MULT, …, MD_MSUBU), the state encoding (ST_IDLE, ST_RUN), and the default latencies.
- One sub-module, md_calc: combinational. Inputs are op, A1, A2, Hi, Lo. Outputs are res[63:0] and a write-enable (low for divide-by-zero). The parent holds the FSM, counter and registers.

## Test plan
- mult A1=0xFFFFFFFF, A2=2 → Busy high exactly 5 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. multu with the same operands → Hi=0x00000001, Lo=0xFFFFFFFE.
- div A1=0xFFFFFFF9 (−7), A2=2 → after 10 Busy cycles, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. divu 7/2 → Lo=3, Hi=1. div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0, then div x/0 → Busy 10 cycles, then Hi=0x12345678 and Lo=0x9ABCDEF0 unchanged.
- Start mult, then during Busy issue Start mthi 0xDEAD and Start divu → both ignored. Only the mult result lands, and Busy falls after 5 cycles.
- Assert reset at the 4th Busy cycle of a div → Busy=0, Hi=Lo=0 immediately without waiting for a clock edge; a later mult completes normally.
- With MULT_DIV_MADD_EN: Hi=0, Lo=0x10, madd 3×4 → Lo=0x1C; msubu 0×… leaves values unchanged. Without the macro: code 0111 with Start → Busy stays 0 and Hi/Lo are unchanged.
